// File: rtl/dot_product_feeder.sv
// dot_product_feeder: loads B beats into the dot-product B-RAM, then streams
// framed A vectors into it, counts the returned results and flags job completion.
// Ports:
//   i_clk, i_reset_n             clock, async active-low reset
//   i_start, i_len, i_num_vec    job request (sampled in IDLE only)
//   i_b_data/i_b_valid/o_b_ready upstream B stream (consumed in LOAD)
//   i_a_data/i_a_valid/o_a_ready upstream A stream (consumed in COMPUTE)
//   o_a, o_b, o_b_addr, o_wren,  registered dot-product pins
//   o_first, o_last
//   i_dp_valid                   result strobe from the dot-product block
//   o_busy, o_done, o_err        status: not idle, job done pulse, sticky error
module dot_product_feeder #(
  parameter int N = 8,
  parameter int M = 8,
  parameter int A = 10,
  parameter int V = 16
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  input  logic           i_start,
  input  logic [A:0]     i_len,
  input  logic [V-1:0]   i_num_vec,
  input  logic [M*N-1:0] i_b_data,
  input  logic           i_b_valid,
  output logic           o_b_ready,
  input  logic [M*N-1:0] i_a_data,
  input  logic           i_a_valid,
  output logic           o_a_ready,
  output logic [M*N-1:0] o_a,
  output logic [M*N-1:0] o_b,
  output logic [A-1:0]   o_b_addr,
  output logic           o_wren,
  output logic           o_first,
  output logic           o_last,
  input  logic           i_dp_valid,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_err
);

  localparam int W  = M * N;
  localparam int LW = A + 1;
  localparam logic [LW-1:0] LEN_MAX = {1'b1, {A{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMP,
    S_DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] wcnt_q, wcnt_d;
  logic [LW-1:0] bcnt_q, bcnt_d;
  logic [V-1:0]  nvec_q, nvec_d;
  logic [V-1:0]  vcnt_q, vcnt_d;
  logic [V-1:0]  rcnt_q, rcnt_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [A-1:0]  addr_q, addr_d;
  logic          wren_q, wren_d;
  logic          first_q, first_d;
  logic          last_q, last_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [LW-1:0] len_m1;
  logic          start_ok;
  logic          in_res;

  assign len_m1   = len_q - LW'(1);
  assign start_ok = i_start
                 && (i_len != '0)
                 && (i_len <= LEN_MAX)
                 && (i_num_vec != '0);
  assign in_res   = (state_q == S_COMP)
                 || (state_q == S_DRAIN);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    nvec_d  = nvec_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    vcnt_d  = vcnt_q;
    rcnt_d  = rcnt_q;
    a_d     = '0;
    b_d     = b_q;
    addr_d  = addr_q;
    wren_d  = 1'b0;
    first_d = 1'b0;
    last_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          len_d   = i_len;
          nvec_d  = i_num_vec;
          wcnt_d  = '0;
          bcnt_d  = '0;
          vcnt_d  = '0;
          rcnt_d  = '0;
          err_d   = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (i_b_valid) begin
          wren_d = 1'b1;
          b_d    = i_b_data;
          addr_d = wcnt_q[A-1:0];
          wcnt_d = wcnt_q + LW'(1);
          if (wcnt_q == len_m1) begin
            state_d = S_COMP;
          end
        end
      end
      S_COMP: begin
        // Stall cycles fall through with a_d=0 and no
        // framing, so the accumulator adds zero.
        if (i_a_valid) begin
          a_d     = i_a_data;
          addr_d  = bcnt_q[A-1:0];
          first_d = (bcnt_q == '0);
          last_d  = (bcnt_q == len_m1);
          if (bcnt_q == len_m1) begin
            bcnt_d = '0;
            vcnt_d = vcnt_q + V'(1);
            if (vcnt_q + V'(1) == nvec_q) begin
              state_d = S_DRAIN;
            end
          end else begin
            bcnt_d = bcnt_q + LW'(1);
          end
        end
      end
      S_DRAIN: begin
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Result counting overrides the stream
    // transitions: the job ends on the last result.
    if (i_dp_valid) begin
      if (in_res && (rcnt_q != nvec_q)) begin
        rcnt_d = rcnt_q + V'(1);
        if (rcnt_q + V'(1) == nvec_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      nvec_q  <= '0;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      vcnt_q  <= '0;
      rcnt_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      addr_q  <= '0;
      wren_q  <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      nvec_q  <= nvec_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      vcnt_q  <= vcnt_d;
      rcnt_q  <= rcnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      addr_q  <= addr_d;
      wren_q  <= wren_d;
      first_q <= first_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_b_ready = (state_q == S_LOAD);
  assign o_a_ready = (state_q == S_COMP);
  assign o_busy    = (state_q != S_IDLE);
  assign o_a       = a_q;
  assign o_b       = b_q;
  assign o_b_addr  = addr_q;
  assign o_wren    = wren_q;
  assign o_first   = first_q;
  assign o_last    = last_q;
  assign o_done    = done_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_dot_product_feeder.sv
// tb_dot_product_feeder: directed job table plus hand sequences for
// reset, illegal starts and error injection, with a dot-product pin model.
module tb_dot_product_feeder;

  localparam int N = 8;
  localparam int M = 8;
  localparam int A = 10;
  localparam int V = 16;
  localparam int W = M * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_start;
  logic [A:0]   i_len;
  logic [V-1:0] i_num_vec;
  logic [W-1:0] b_data, a_data;
  logic         b_valid, a_valid;
  logic         o_b_ready, o_a_ready;
  logic [W-1:0] o_a, o_b;
  logic [A-1:0] o_b_addr;
  logic         o_wren, o_first, o_last;
  logic         dp_valid, dp_m, dp_inj;
  logic         o_busy, o_done, o_err;

  always #5 clk = ~clk;
  assign dp_valid = dp_m | dp_inj;

  dot_product_feeder #(.N(N), .M(M), .A(A), .V(V)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_start(i_start), .i_len(i_len), .i_num_vec(i_num_vec),
    .i_b_data(b_data), .i_b_valid(b_valid), .o_b_ready(o_b_ready),
    .i_a_data(a_data), .i_a_valid(a_valid), .o_a_ready(o_a_ready),
    .o_a(o_a), .o_b(o_b), .o_b_addr(o_b_addr), .o_wren(o_wren),
    .o_first(o_first), .o_last(o_last), .i_dp_valid(dp_valid),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail_to(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timeout", nm);
  endtask

  function automatic logic [W-1:0] bbeat(input int j);
    logic [7:0] x;
    x = 8'((j % 4) + 1);
    return {8{x}};
  endfunction

  function automatic logic [W-1:0] abeat(input int v);
    logic [7:0] x;
    x = 8'(v);
    if (v == 0) return {{4{8'd2}}, {4{8'd1}}};
    return {8{x}};
  endfunction

  function automatic longint dot(input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    longint s;
    s = 0;
    for (int l = 0; l < M; l++)
      s += longint'(a[l*8+:8]) * longint'(b[l*8+:8]);
    return s;
  endfunction

  // Model of the dot-product block: B-RAM, accumulator,
  // result strobe two cycles after the last beat.
  logic [W-1:0] bram [0:1023];
  int     wren_cnt, wr_err, first_cnt, last_cnt, rd_err;
  int     done_cnt, cur_len;
  longint acc, dd;
  longint sums [$];
  logic [1:0] dly;

  task automatic mon_reset();
    wren_cnt = 0; wr_err = 0; first_cnt = 0; last_cnt = 0;
    rd_err = 0; done_cnt = 0; acc = 0; dly = '0; dp_m = 1'b0;
    sums.delete();
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      dly = '0;
      dp_m = 1'b0;
    end else begin
      dp_m = dly[1];
      dly = {dly[0], o_last};
      if (o_wren) begin
        if (o_b_addr != 10'(wren_cnt) || o_b != bbeat(wren_cnt))
          wr_err++;
        bram[o_b_addr] = o_b;
        wren_cnt++;
      end
      dd = dot(o_a, bram[o_b_addr]);
      if (o_first) begin
        acc = dd;
        first_cnt++;
        if (o_b_addr != '0) rd_err++;
      end else begin
        acc += dd;
      end
      if (o_last) begin
        sums.push_back(acc);
        last_cnt++;
        if (o_b_addr != 10'(cur_len - 1)) rd_err++;
      end
      if (o_done) done_cnt++;
    end
  end

  typedef struct {
    int     len;
    int     nv;
    int     stall;
    longint s0;
    longint s1;
    longint s2;
  } vec_t;

  vec_t tab [6];

  task automatic do_start(input int len, input int nv);
    @(posedge clk); #1;
    mon_reset();
    cur_len = len;
    @(negedge clk);
    i_start = 1'b1;
    i_len = 11'(len);
    i_num_vec = 16'(nv);
    @(negedge clk);
    i_start = 1'b0;
    chk("start_busy", 64'(o_busy), 64'd1);
    chk("start_err", 64'(o_err), 64'd0);
  endtask

  task automatic do_load(input int len, input bit poke);
    for (int j = 0; j < len; j++) begin
      int t = 0;
      b_valid = 1'b1;
      b_data = bbeat(j);
      if (poke) begin
        i_start = (j == 0);
        i_len = 11'd2;
        i_num_vec = 16'd5;
      end
      while (!o_b_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (t >= 20) fail_to("load_ready");
      @(negedge clk);
    end
    i_start = 1'b0;
    b_data = '1;
  endtask

  task automatic do_beat(input int v);
    int t = 0;
    a_valid = 1'b1;
    a_data = abeat(v);
    while (!o_a_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) fail_to("a_ready");
    @(negedge clk);
  endtask

  task automatic do_stall(input int n);
    for (int s = 0; s < n; s++) begin
      a_valid = 1'b0;
      a_data = '1;
      @(posedge clk); #1;
      chk("bubble_a", o_a, 64'd0);
      chk("bubble_fl", 64'({o_first, o_last}), 64'd0);
      @(negedge clk);
    end
  endtask

  task automatic run_job(input vec_t r, input bit poke);
    int t;
    int sj;
    longint e;
    sj = (r.len > 2) ? 2 : 0;
    do_start(r.len, r.nv);
    do_load(r.len, poke);
    for (int v = 0; v < r.nv; v++)
      for (int j = 0; j < r.len; j++) begin
        if (r.stall != 0 && v == 1 && j == sj) do_stall(r.stall);
        do_beat(v);
      end
    a_data = '1;
    t = 0;
    while (done_cnt == 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) fail_to("job_done");
    repeat (3) @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
    chk("wren_cnt", 64'(wren_cnt), 64'(r.len));
    chk("wr_seq", 64'(wr_err), 64'd0);
    chk("first_cnt", 64'(first_cnt), 64'(r.nv));
    chk("last_cnt", 64'(last_cnt), 64'(r.nv));
    chk("rd_addr", 64'(rd_err), 64'd0);
    chk("n_sums", 64'(sums.size()), 64'(r.nv));
    for (int v = 0; v < r.nv && v < sums.size(); v++) begin
      e = (v == 0) ? r.s0 : ((v == 1) ? r.s1 : r.s2);
      chk("sum", 64'(sums[v]), 64'(e));
    end
    chk("done_cnt", 64'(done_cnt), 64'd1);
    chk("end_busy", 64'(o_busy), 64'd0);
    chk("end_err", 64'(o_err), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0] = '{len: 4,    nv: 2, stall: 0, s0: 120,   s1: 80, s2: 0};
    tab[1] = '{len: 4,    nv: 2, stall: 3, s0: 120,   s1: 80, s2: 0};
    tab[2] = '{len: 1,    nv: 3, stall: 0, s0: 12,    s1: 8,  s2: 16};
    tab[3] = '{len: 1,    nv: 3, stall: 2, s0: 12,    s1: 8,  s2: 16};
    tab[4] = '{len: 3,    nv: 2, stall: 0, s0: 72,    s1: 48, s2: 0};
    tab[5] = '{len: 1024, nv: 1, stall: 0, s0: 30720, s1: 0,  s2: 0};

    for (int i = 0; i < 1024; i++) bram[i] = '0;
    rst_n = 1'b1;
    i_start = 1'b0; i_len = '0; i_num_vec = '0;
    b_data = '0; a_data = '0; b_valid = 1'b0; a_valid = 1'b0;
    dp_inj = 1'b0;
    mon_reset();
    cur_len = 1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_ctrl", 64'({o_wren, o_first, o_last, o_done, o_err}), 64'd0);
    chk("rst_rdy", 64'({o_a_ready, o_b_ready}), 64'd0);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_job(tab[i], 1'b0);

    // Reset during vector 2 of 4.
    do_start(4, 4);
    do_load(4, 1'b0);
    for (int k = 0; k < 6; k++) do_beat(k / 4);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(o_busy), 64'd0);
    chk("mid_rst_a", o_a, 64'd0);
    chk("mid_rst_b", o_b, 64'd0);
    chk("mid_rst_addr", 64'(o_b_addr), 64'd0);
    chk("mid_rst_ctrl",
        64'({o_wren, o_first, o_last, o_done, o_err, o_a_ready, o_b_ready}),
        64'd0);
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    run_job(tab[0], 1'b0);

    // Illegal job requests.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      i_start = 1'b1;
      i_len = (k == 0) ? 11'd0 : ((k == 1) ? 11'd1025 : 11'd4);
      i_num_vec = (k == 2) ? 16'd0 : 16'd1;
      @(negedge clk);
      i_start = 1'b0;
      chk("bad_start_busy", 64'(o_busy), 64'd0);
    end

    // Result strobe while idle sets a sticky error.
    @(negedge clk);
    dp_inj = 1'b1;
    @(negedge clk);
    dp_inj = 1'b0;
    chk("idle_err", 64'(o_err), 64'd1);
    repeat (3) @(negedge clk);
    chk("idle_err_held", 64'(o_err), 64'd1);
    // Start clears it; a start poked during LOAD is ignored.
    run_job(tab[0], 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
